// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sched_if
// Description : Bundles the request/config inputs and the grant/clock/status
//               outputs of the shared clock-divider scheduler.
//               slave  - scheduler side (receives req/div_cfg, drives the rest)
//               master - requester side (drives req/div_cfg, observes the rest)
// Signals     : req[NREQ]            level request per requester
//               div_cfg[NREQ*CNT_W]  packed divide ratios, slot i at [i*CNT_W +: CNT_W]
//               grant[NREQ]          one-hot divider owner, zero when idle
//               clk_o                registered divided clock
//               tick                 pulse in last clk cycle of each clk_o period
//               busy                 scheduler not idle
//               cfg_err              pulse when a granted ratio is below 2
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_sched_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] div_cfg;
    logic [NREQ-1:0]       grant;
    logic                  clk_o;
    logic                  tick;
    logic                  busy;
    logic                  cfg_err;

    modport slave (
        input  req,
        input  div_cfg,
        output grant,
        output clk_o,
        output tick,
        output busy,
        output cfg_err
    );

    modport master (
        output req,
        output div_cfg,
        input  grant,
        input  clk_o,
        input  tick,
        input  busy,
        input  cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sched
// Description : Shared programmable clock divider. A round-robin arbiter hands
//               the single divider counter to one requester at a time; the
//               owner only changes on a divided-period boundary so clk_o never
//               carries a truncated high or low phase. An owner keeps the
//               divider for at least HOLD_PERIODS full periods while others
//               wait, and indefinitely if nobody else asks.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - clk_div_sched_if.slave (req, div_cfg in;
//                      grant, clk_o, tick, busy, cfg_err out)
// Options     : DIV_SCHED_HANDOVER_EN - when defined, a release with another
//               request pending goes straight to LOAD of the next owner
//               (grant switches one-hot to one-hot, no IDLE cycle).
//               Undefined: every release passes through one IDLE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int NREQ         = 4,
    parameter int CNT_W        = 8,
    parameter int HOLD_PERIODS = 4
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_sched_if.slave bus
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_PC_W  = $clog2(HOLD_PERIODS) + 1;

    localparam logic [c_IDX_W:0]   c_NREQ_EXT = (c_IDX_W + 1)'(NREQ);
    localparam logic [c_IDX_W-1:0] c_RR_INIT  = c_IDX_W'(NREQ - 1);
    localparam logic [c_PC_W-1:0]  c_HOLD     = c_PC_W'(HOLD_PERIODS);
    localparam logic [c_PC_W:0]    c_HOLD_EXT = (c_PC_W + 1)'(HOLD_PERIODS);
    localparam logic [CNT_W-1:0]   c_MIN_N    = CNT_W'(2);

`ifdef DIV_SCHED_HANDOVER_EN
    localparam bit c_HANDOVER = 1'b1;
`else
    localparam bit c_HANDOVER = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic [NREQ-1:0]     r_grant;
    logic [c_IDX_W-1:0]  r_rr_ptr;     // last winner == current owner
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_h;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_PC_W-1:0]   r_period_cnt;
    logic                r_clk_o;
    logic                r_tick;
    logic                r_cfg_err;

    // Next-state values
    state_t              w_state_nxt;
    logic [NREQ-1:0]     w_grant_nxt;
    logic [c_IDX_W-1:0]  w_rr_ptr_nxt;
    logic [CNT_W-1:0]    w_n_nxt;
    logic [CNT_W-1:0]    w_h_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [c_PC_W-1:0]   w_period_cnt_nxt;
    logic                w_clk_o_nxt;
    logic                w_tick_nxt;
    logic                w_cfg_err_nxt;

    // Helpers
    logic [CNT_W-1:0]    w_cfg [NREQ];
    logic [CNT_W-1:0]    w_n_sel;
    logic [CNT_W-1:0]    w_h_sel;
    logic                w_win_any;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic [NREQ-1:0]     w_win_oh;
    logic [c_IDX_W:0]    w_scan;
    logic                w_last;
    logic                w_other;
    logic [c_PC_W:0]     w_pc_inc;
    logic [c_PC_W-1:0]   w_pc_sat;
    logic                w_release;

    // Unpack the ratio bus into one slot per requester
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cfg
        assign w_cfg[gi] = bus.div_cfg[gi*CNT_W +: CNT_W];
    end

    // Ratio of the current owner; high phase is the larger half so odd
    // ratios stay high one cycle longer than low.
    assign w_n_sel = w_cfg[r_rr_ptr];
    assign w_h_sel = w_n_sel - (w_n_sel >> 1);

    // Round-robin scan starting just after the last winner; the last winner
    // itself is tried last so it only wins again when nobody else asks.
    always_comb begin
        w_win_any = 1'b0;
        w_win_idx = '0;
        w_scan    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(i);
            if (w_scan >= c_NREQ_EXT) begin
                w_scan = w_scan - c_NREQ_EXT;
            end
            if (!w_win_any && bus.req[w_scan[c_IDX_W-1:0]]) begin
                w_win_any = 1'b1;
                w_win_idx = w_scan[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_oh            = '0;
        w_win_oh[w_win_idx] = 1'b1;
    end

    assign w_last    = (r_cnt == r_n - 1'b1);
    assign w_other   = |(bus.req & ~r_grant);
    // One bit wider than period_cnt so the +1 compare cannot wrap
    assign w_pc_inc  = {1'b0, r_period_cnt} + 1'b1;
    assign w_pc_sat  = (r_period_cnt >= c_HOLD) ? r_period_cnt : w_pc_inc[c_PC_W-1:0];
    assign w_release = !bus.req[r_rr_ptr] || ((w_pc_inc >= c_HOLD_EXT) && w_other);

    // Next-state and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_n_nxt          = r_n;
        w_h_nxt          = r_h;
        w_cnt_nxt        = r_cnt;
        w_period_cnt_nxt = r_period_cnt;
        w_clk_o_nxt      = 1'b0;
        w_tick_nxt       = 1'b0;
        w_cfg_err_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_win_any) begin
                    w_state_nxt  = S_LOAD;
                    w_grant_nxt  = w_win_oh;
                    w_rr_ptr_nxt = w_win_idx;
                end
            end

            S_LOAD: begin
                w_n_nxt = w_n_sel;
                w_h_nxt = w_h_sel;
                if (w_n_sel < c_MIN_N) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = '0;
                    w_cfg_err_nxt = 1'b1;
                end else begin
                    // cnt starts at 0 and H >= 1, so the first RUN cycle is high;
                    // N >= 2 means cnt 0 is never the last cycle.
                    w_state_nxt      = S_RUN;
                    w_cnt_nxt        = '0;
                    w_period_cnt_nxt = '0;
                    w_clk_o_nxt      = 1'b1;
                end
            end

            S_RUN: begin
                if (w_last) begin
                    w_period_cnt_nxt = w_pc_sat;
                    if (w_release) begin
                        if (c_HANDOVER && w_other) begin
                            w_state_nxt  = S_LOAD;
                            w_grant_nxt  = w_win_oh;
                            w_rr_ptr_nxt = w_win_idx;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_grant_nxt = '0;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_clk_o_nxt = 1'b1;
                    end
                end else begin
                    // clk_o and tick are computed for the cnt value they will
                    // accompany, keeping both aligned with the counter.
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_clk_o_nxt = ((r_cnt + 1'b1) < r_h);
                    w_tick_nxt  = ((r_cnt + 1'b1) == (r_n - 1'b1));
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= c_RR_INIT;
            r_n          <= '0;
            r_h          <= '0;
            r_cnt        <= '0;
            r_period_cnt <= '0;
            r_clk_o      <= 1'b0;
            r_tick       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_n          <= w_n_nxt;
            r_h          <= w_h_nxt;
            r_cnt        <= w_cnt_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_clk_o      <= w_clk_o_nxt;
            r_tick       <= w_tick_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    assign bus.grant   = r_grant;
    assign bus.clk_o   = r_clk_o;
    assign bus.tick    = r_tick;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.cfg_err = r_cfg_err;

endmodule
`default_nettype wire
